// File: rtl/operand_stack_pkg.sv
// Shared definitions for the operand stack: operation and strobe-FSM
// encodings plus the default geometry.
package stack_defs;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 16;

    // Operation decoded from {pop, push} at a commit edge.
    typedef enum logic [1:0] {
        OP_NONE    = 2'b00,
        OP_PUSH    = 2'b01,
        OP_POP     = 2'b10,
        OP_REPLACE = 2'b11
    } op_e;

    // Strobe FSM: READY waits for stack_clk to rise, HELD waits for it to fall.
    typedef enum logic {
        ST_READY = 1'b0,
        ST_HELD  = 1'b1
    } state_e;

endpackage

// File: rtl/operand_stack_strobe_edge.sv
// stack_strobe_edge: turns the controller's level strobe stack_clk into a
// single-cycle commit pulse, however long the strobe stays high.
//
// Strobe semantics: an operation commits on the first rising clk edge at
// which stack_clk = 1 while the FSM is in ST_READY. commit is asserted
// combinationally during that cycle. The strobe must return to 0 for at
// least one edge before another operation can commit. A same-cycle soft
// clear (rst) or an active reset suppresses the commit.
module stack_strobe_edge
    import stack_defs::*;
(
    input  logic clk,
    input  logic reset,
    input  logic rst,
    input  logic stack_clk,
    output logic commit
);

    state_e state;

    // Two-state edge detector on the strobe level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_READY;
        end else if (rst) begin
            state <= stack_clk ? ST_HELD : ST_READY;
        end else begin
            case (state)
                ST_READY: if (stack_clk)  state <= ST_HELD;
                ST_HELD:  if (!stack_clk) state <= ST_READY;
                default:                  state <= ST_READY;
            endcase
        end
    end

    // Commit lasts exactly the cycle in which the rising strobe is seen.
    assign commit = reset && !rst && stack_clk && (state == ST_READY);

endmodule

// File: rtl/operand_stack.sv
// operand_stack: LIFO holding ALU operands and results for the stack machine.
// Push/pop/replace commit on the rising stack_clk strobe; the top of stack
// is presented combinationally from registered state.
// Optional sticky overflow/underflow flags: define OPERAND_STACK_ERR_FLAGS_EN.
module operand_stack
    import stack_defs::*;
#(
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int DEPTH  = DEPTH_DEF,
    localparam int CNT_W  = $clog2(DEPTH) + 1
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              rst,
    input  logic              stack_clk,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] data_to_push,
    output logic [DATA_W-1:0] data_from_stack,
    output logic [CNT_W-1:0]  depth,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [CNT_W-1:0]  depth_q;
    logic [CNT_W-1:0]  depth_nxt;
    logic              commit;
    op_e               op;
    logic              is_empty;
    logic              is_full;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [AW-1:0]     top_addr;

    stack_strobe_edge u_strobe (
        .clk       (clk),
        .reset     (reset),
        .rst       (rst),
        .stack_clk (stack_clk),
        .commit    (commit)
    );

    assign op       = op_e'({pop, push});
    assign is_empty = (depth_q == '0);
    assign is_full  = (depth_q == CNT_W'(DEPTH));
    assign top_addr = AW'(depth_q - CNT_W'(1));

    // Decode the committed operation; illegal pushes/pops leave state alone.
    always_comb begin
        wr_en     = 1'b0;
        wr_addr   = depth_q[AW-1:0];
        depth_nxt = depth_q;
        if (commit) begin
            case (op)
                OP_PUSH: begin
                    if (!is_full) begin
                        wr_en     = 1'b1;
                        depth_nxt = depth_q + CNT_W'(1);
                    end
                end
                OP_POP: begin
                    if (!is_empty) depth_nxt = depth_q - CNT_W'(1);
                end
                OP_REPLACE: begin
                    wr_en = 1'b1;
                    if (is_empty) depth_nxt = depth_q + CNT_W'(1);
                    else          wr_addr   = top_addr;
                end
                default: ;
            endcase
        end
    end

    // Occupancy counter; soft clear wins over any same-cycle operation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)    depth_q <= '0;
        else if (rst)  depth_q <= '0;
        else           depth_q <= depth_nxt;
    end

    // Storage is never cleared; writes only happen on a legal commit.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= data_to_push;
    end

    assign data_from_stack = is_empty ? '0 : mem[top_addr];
    assign depth           = depth_q;
    assign empty           = is_empty;
    assign full            = is_full;

`ifdef OPERAND_STACK_ERR_FLAGS_EN
    logic ovf_set;
    logic unf_set;
    logic ovf_q;
    logic unf_q;

    // A pop (alone or paired with push) on an empty stack is an underflow.
    assign ovf_set = commit && (op == OP_PUSH) && is_full;
    assign unf_set = commit && pop && is_empty;

    // Sticky error flags, cleared only by reset or soft clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (ovf_set) ovf_q <= 1'b1;
            if (unf_set) unf_q <= 1'b1;
        end
    end

    assign overflow  = ovf_q;
    assign underflow = unf_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: doc/operand_stack.md
Name: operand_stack

Overview:
- Stack-side responder for the CPU controller's stack interface.
- Accepts push/pop requests qualified by the controller's `stack_clk` strobe and presents the current top-of-stack on `data_from_stack`.
- Holds ALU operands and results for the stack machine, alongside the values RAM and instruction RAM.
- Fully synchronous to the CPU clock; `stack_clk` is treated as a same-domain level signal, never as a clock.

Parameters:
- DATA_W, 8, width of each stack entry
- DEPTH, 16, number of entries (power of two, ≥2)
- CNT_W, $clog2(DEPTH)+1, width of the occupancy counter (derived, do not override)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- rst  in  1  synchronous soft clear from controller, active-high
- stack_clk  in  1  operation strobe; an operation commits on its 0→1 transition
- push  in  1  push request, sampled with the strobe
- pop  in  1  pop request, sampled with the strobe
- data_to_push  in  DATA_W  value written on push
- data_from_stack  out  DATA_W  current top-of-stack; 0 when empty
- depth  out  CNT_W  number of valid entries, 0..DEPTH
- empty  out  1  depth == 0
- full  out  1  depth == DEPTH
- overflow  out  1  sticky illegal-push flag (see Optional Feature)
- underflow  out  1  sticky illegal-pop flag (see Optional Feature)

Behaviour:
- Reset (`reset` = 0, async): state = ST_READY, depth = 0, overflow = 0, underflow = 0. Storage contents are not cleared. Outputs: data_from_stack = 0, empty = 1, full = 0.
- Strobe FSM, registered `stack_clk` edge detection:
  - ST_READY: if stack_clk = 1, commit the operation at this edge and go to ST_HELD.
  - ST_HELD: stay while stack_clk = 1; return to ST_READY when stack_clk = 0.
  - Holding stack_clk high for many cycles yields exactly one operation.
  - A strobe already high on reset release commits on the first edge after release.
- Operation at commit, decoded from push and pop:
  - push only: mem[depth] ← data_to_push; depth + 1.
  - pop only: depth − 1. The popped value is the one on data_from_stack before the edge (read-then-remove).
  - push and pop with non-empty stack: REPLACE, mem[depth−1] ← data_to_push; depth unchanged.
  - push and pop with empty stack: behaves as push; underflow is set.
  - neither: no operation, but the FSM still enters ST_HELD.
- data_from_stack = mem[depth−1], combinational from registered state.
  - Latency: the new top is visible in the cycle after the commit edge.
  - Value is 0 when empty.
- Boundaries:
  - push when full: ignored (depth and storage unchanged); overflow set.
  - pop when empty: ignored; underflow set.
  - REPLACE when full is legal.
- Soft clear `rst`: takes priority over any same-cycle strobe. depth = 0, flags = 0, FSM = ST_HELD if stack_clk = 1, else ST_READY.
- `reset` asserted mid-operation: immediate clear, no partial write.
- Arithmetic is unsigned. depth never wraps because illegal operations are blocked.

Optional Feature:
- Macro: OPERAND_STACK_ERR_FLAGS_EN
- Defined:
  - overflow and underflow are sticky flags, set as described above.
  - Cleared only by `reset` or `rst`.
- Undefined:
  - overflow and underflow are tied to 0.
  - Illegal operations are still silently ignored.
  - Flag registers are not instantiated.

Decomposition:
- Shared package stack_defs:
  - op encoding: OP_NONE = 2'b00, OP_PUSH = 2'b01, OP_POP = 2'b10, OP_REPLACE = 2'b11
  - FSM state encoding: ST_READY, ST_HELD
  - default DATA_W and DEPTH constants
- Sub-module stack_strobe_edge: the two-state strobe FSM with inputs clk, reset, rst and stack_clk, and a one-cycle `commit` output.
- Storage and pointer logic stay in operand_stack.

Test Plan:
- Reset, then push 0x05, 0x0A, 0x0F, each with a one-cycle stack_clk pulse → depth = 3, data_from_stack = 0x0F; three pops read 0x0F, 0x0A, 0x05; empty = 1, data_from_stack = 0.
- stack_clk held high 5 cycles with push = 1, data 0x33 → exactly one push, depth = 1.
- Fill 16 entries (0x00..0x0F), push 0xAA → depth = 16, top = 0x0F, full = 1, overflow = 1 (flag macro defined) or 0 (undefined).
- Empty stack, pop strobe → depth = 0, underflow = 1. Then push = pop = 1 with 0x44 → depth = 1, top = 0x44.
- depth = 2, top = 0x07, push = pop = 1 with 0x09 → depth = 2, top = 0x09, below-top entry unchanged.
- Strobe and rst in the same cycle with depth = 4 → depth = 0, no push. `reset` pulsed low mid-sequence → all outputs at reset values asynchronously.
